// File: rtl/dual_debounce_pkg.sv
// Shared types and defaults for the two-channel debouncer.
// Holds the per-channel FSM state type and the saturating glitch-count helper.
package dual_debounce_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int GLITCH_W                = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_e;

  function automatic logic is_stable(input db_state_e st);
    return (st == STABLE_LO) || (st == STABLE_HI);
  endfunction

  // Adds 0..2 glitch events per cycle and clamps at the all-ones value.
  function automatic logic [GLITCH_W-1:0] glitch_add(input logic [GLITCH_W-1:0] cnt,
                                                     input logic [1:0]          inc);
    logic [GLITCH_W:0] sum;
    sum = {1'b0, cnt} + {{(GLITCH_W-1){1'b0}}, inc};
    return sum[GLITCH_W] ? {GLITCH_W{1'b1}} : sum[GLITCH_W-1:0];
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser chain, 4-state FSM with disagreement
// counter, registered level and edge pulses, and a combinational glitch strobe.
module debounce_channel
  import dual_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic glitch,
  output logic stable_next
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d;
  logic                   pending, disagree, done;

  // The raw pin is asynchronous; only the last stage of this chain is trusted.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the pre-edge values and simulation order cannot change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign pending  = (state_q == PEND_HI) || (state_q == PEND_LO);
  assign disagree = s ^ level;
  assign done     = disagree && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE_LO: if (s) begin
        state_d = PEND_HI;
        cnt_d   = CW'(1);
      end
      STABLE_HI: if (!s) begin
        state_d = PEND_LO;
        cnt_d   = CW'(1);
      end
      PEND_HI, PEND_LO: begin
        if (!disagree)
          state_d = (state_q == PEND_HI) ? STABLE_LO : STABLE_HI;
        else if (done)
          state_d = (state_q == PEND_HI) ? STABLE_HI : STABLE_LO;
        else
          cnt_d = cnt_q + CW'(1);
      end
      default: state_d = STABLE_LO;
    endcase
  end

  // Pulses are computed here and registered, so they appear together with the
  // updated level for exactly one cycle.
  always_comb begin
    rise_d      = pending && done && !level;
    fall_d      = pending && done &&  level;
    level_d     = level ^ (pending && done);
    glitch      = pending && !disagree;
    stable_next = is_stable(state_d);
  end

endmodule

// File: rtl/dual_debounce.sv
// Two independent debounced inputs feeding a downstream boolean stage, with a
// shared saturating glitch counter and a registered both-settled flag.
module dual_debounce
  import dual_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                raw1,
  input  logic                raw2,
  input  logic                clr_glitch,
  output logic                in1,
  output logic                in2,
  output logic                rise1,
  output logic                fall1,
  output logic                rise2,
  output logic                fall2,
  output logic                settled,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  logic glitch1, glitch2;
  logic stable1, stable2;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (raw1),
    .level      (in1),
    .rise       (rise1),
    .fall       (fall1),
    .glitch     (glitch1),
    .stable_next(stable1)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (raw2),
    .level      (in2),
    .rise       (rise2),
    .fall       (fall2),
    .glitch     (glitch2),
    .stable_next(stable2)
  );

  // Clear has priority over any glitch arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
      settled    <= 1'b1;
    end else begin
      glitch_cnt <= clr_glitch ? '0
                  : glitch_add(glitch_cnt, {1'b0, glitch1} + {1'b0, glitch2});
      settled    <= stable1 && stable2;
    end
  end

endmodule
